// File: rtl/pm_frame_builder.sv
// pm_frame_builder
//   Expands packet commands from the shared command FIFO into Ethernet frames
//   (no FCS) on an 8-bit AXI-Stream master, one byte per beat. Every frame has
//   a 14-byte header (dst MAC, src MAC, EtherType, each least significant
//   byte first) and cmd_size payload bytes. A forced idle gap follows each
//   frame. Illegal sizes are dropped and counted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command FIFO handshake (cmd_ready acts as the pop strobe)
//   cmd_size..payload   head-of-FIFO command fields
//   m_axis_*            8-bit AXI-Stream master toward the MAC TX path
//   busy                not idle, or a size check is pending
//   frame_count         completed frames (wraps)
//   drop_count          dropped commands (saturates)
//   drop_pulse          one cycle per dropped command
module pm_frame_builder #(
    parameter int MAX_SIZE     = 1500,
    parameter int IFG_CYCLES   = 12,
    parameter int PAYLOAD_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_size,
    input  logic [47:0] cmd_d_mac,
    input  logic [47:0] cmd_s_mac,
    input  logic [15:0] cmd_ethertype,
    input  logic [7:0]  cmd_payload,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic        drop_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    state_t         state_q, state_d;
    logic           chk_q, chk_d;      // size check pending on the latched command
    logic           rdy_q, rdy_d;
    logic [10:0]    idx_q, idx_d;      // header or payload byte index
    logic [10:0]    size_q, size_d;
    logic [47:0]    dmac_q, dmac_d;
    logic [47:0]    smac_q, smac_d;
    logic [15:0]    et_q, et_d;
    logic [7:0]     seed_q, seed_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [31:0]    fc_q, fc_d;
    logic [15:0]    dc_q, dc_d;

    logic           pop;
    logic           hs;
    logic           legal;
    logic           last_beat;
    logic [111:0]   hdr;

    assign pop       = cmd_valid && rdy_q;
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign legal     = (size_q != 11'd0) && ({21'd0, size_q} <= 32'(MAX_SIZE));
    assign last_beat = (state_q == S_PAY) && (idx_q == size_q - 11'd1);
    // Header laid out so that byte i sits at bits [8i+7:8i].
    assign hdr       = {et_q, smac_q, dmac_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chk_q   <= 1'b0;
            rdy_q   <= 1'b0;
            idx_q   <= '0;
            size_q  <= '0;
            dmac_q  <= '0;
            smac_q  <= '0;
            et_q    <= '0;
            seed_q  <= '0;
            gap_q   <= '0;
            fc_q    <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            rdy_q   <= rdy_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            dmac_q  <= dmac_d;
            smac_q  <= smac_d;
            et_q    <= et_d;
            seed_q  <= seed_d;
            gap_q   <= gap_d;
            fc_q    <= fc_d;
            dc_q    <= dc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        size_d  = size_q;
        dmac_d  = dmac_q;
        smac_d  = smac_q;
        et_d    = et_q;
        seed_d  = seed_q;
        gap_d   = gap_q;
        fc_d    = fc_q;
        dc_d    = dc_q;

        case (state_q)
            S_IDLE: begin
                if (chk_q) begin
                    chk_d = 1'b0;
                    if (legal) begin
                        state_d = S_HDR;
                        idx_d   = '0;
                    end else if (dc_q != 16'hFFFF) begin
                        dc_d = dc_q + 16'd1;
                    end
                end else if (pop) begin
                    chk_d  = 1'b1;
                    size_d = cmd_size;
                    dmac_d = cmd_d_mac;
                    smac_d = cmd_s_mac;
                    et_d   = cmd_ethertype;
                    seed_d = cmd_payload;
                end
            end
            S_HDR: begin
                if (hs) begin
                    if (idx_q == 11'd13) begin
                        state_d = S_PAY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            S_PAY: begin
                if (hs) begin
                    if (last_beat) begin
                        fc_d    = fc_q + 32'd1;
                        state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                        gap_d   = '0;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Ready is registered: it rises together with the state entering IDLE
        // and falls right after a pop so the size check sees exactly one command.
        rdy_d = (state_d == S_IDLE) && !chk_d;
    end

    // Outputs
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        case (state_q)
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr[{idx_q[3:0], 3'b000} +: 8];
            end
            S_PAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = (PAYLOAD_MODE == 1) ? seed_q + idx_q[7:0] : seed_q;
            end
            default: ;
        endcase
    end

    assign m_axis_tlast = last_beat;
    assign cmd_ready    = rdy_q;
    assign busy         = (state_q != S_IDLE) || chk_q;
    assign drop_pulse   = chk_q && !legal;
    assign frame_count  = fc_q;
    assign drop_count   = dc_q;

endmodule

// File: tb/tb_pm_frame_builder.sv
module tb_pm_frame_builder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [10:0] cmd_size [2];
    logic [47:0] cmd_d_mac [2];
    logic [47:0] cmd_s_mac [2];
    logic [15:0] cmd_ethertype [2];
    logic [7:0]  cmd_payload [2];
    logic [7:0]  tdata [2];
    logic        tvalid [2];
    logic        tready [2];
    logic        tlast [2];
    logic        busy [2];
    logic [31:0] frame_count [2];
    logic [15:0] drop_count [2];
    logic        drop_pulse [2];

    // Instance 0: constant payload, 12-cycle gap. Instance 1: incrementing payload, no gap.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pm_frame_builder #(
            .MAX_SIZE    (1500),
            .IFG_CYCLES  (g == 0 ? 12 : 0),
            .PAYLOAD_MODE(g)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_size     (cmd_size[g]),
            .cmd_d_mac    (cmd_d_mac[g]),
            .cmd_s_mac    (cmd_s_mac[g]),
            .cmd_ethertype(cmd_ethertype[g]),
            .cmd_payload  (cmd_payload[g]),
            .m_axis_tdata (tdata[g]),
            .m_axis_tvalid(tvalid[g]),
            .m_axis_tready(tready[g]),
            .m_axis_tlast (tlast[g]),
            .busy         (busy[g]),
            .frame_count  (frame_count[g]),
            .drop_count   (drop_count[g]),
            .drop_pulse   (drop_pulse[g])
        );
    end

    typedef struct {
        logic [10:0] size;
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] et;
        logic [7:0]  pl;
    } cmd_t;

    cmd_t        fifo0[$], fifo1[$];
    logic [8:0]  sb0[$], sb1[$];   // {tlast, tdata} expected per beat

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int beat_cnt [2], last_len [2], tl_cyc [2], gap_meas [2], drop_seen [2];
    int exp_fc [2], exp_dc [2];
    logic rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void sb_push(input int d, input logic [8:0] v);
        if (d == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endfunction

    function automatic logic [8:0] sb_pop(input int d);
        if (d == 0 && sb0.size() > 0) return sb0.pop_front();
        if (d == 1 && sb1.size() > 0) return sb1.pop_front();
        return 9'bx;
    endfunction

    function automatic int pend(input int d);
        return (d == 0) ? fifo0.size() + sb0.size() : fifo1.size() + sb1.size();
    endfunction

    // Queue a command into the FIFO model and push the frame it must produce.
    task automatic send(input int d, input logic [10:0] sz, input logic [47:0] dm,
                        input logic [47:0] sm, input logic [15:0] et, input logic [7:0] pl);
        cmd_t c;
        c.size = sz; c.dm = dm; c.sm = sm; c.et = et; c.pl = pl;
        if (sz != 0 && sz <= 1500) begin
            for (int i = 0; i < 6; i++) sb_push(d, {1'b0, dm[8*i +: 8]});
            for (int i = 0; i < 6; i++) sb_push(d, {1'b0, sm[8*i +: 8]});
            sb_push(d, {1'b0, et[7:0]});
            sb_push(d, {1'b0, et[15:8]});
            for (int p = 0; p < int'(sz); p++)
                sb_push(d, {p == int'(sz) - 1, (d == 1) ? pl + 8'(p) : pl});
            exp_fc[d]++;
        end else begin
            exp_dc[d]++;
        end
        if (d == 0) fifo0.push_back(c);
        else        fifo1.push_back(c);
    endtask

    task automatic wait_idle(input int d, input int max);
        int n = 0;
        while ((pend(d) != 0 || busy[d] || cmd_valid[d]) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", d), 64'(n < max), 1);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO model and sink ready generation.
    logic pop0, pop1;
    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; tready[d] = 1'b1;
            cmd_size[d] = '0; cmd_d_mac[d] = '0; cmd_s_mac[d] = '0;
            cmd_ethertype[d] = '0; cmd_payload[d] = '0;
        end
        forever begin
            @(posedge clk);
            pop0 = cmd_valid[0] && cmd_ready[0];
            pop1 = cmd_valid[1] && cmd_ready[1];
            #1;
            if (pop0) void'(fifo0.pop_front());
            if (pop1) void'(fifo1.pop_front());
            cmd_valid[0] = fifo0.size() != 0;
            cmd_valid[1] = fifo1.size() != 0;
            if (fifo0.size() != 0) begin
                cmd_size[0] = fifo0[0].size; cmd_d_mac[0] = fifo0[0].dm; cmd_s_mac[0] = fifo0[0].sm;
                cmd_ethertype[0] = fifo0[0].et; cmd_payload[0] = fifo0[0].pl;
            end
            if (fifo1.size() != 0) begin
                cmd_size[1] = fifo1[0].size; cmd_d_mac[1] = fifo1[0].dm; cmd_s_mac[1] = fifo1[0].sm;
                cmd_ethertype[1] = fifo1[0].et; cmd_payload[1] = fifo1[0].pl;
            end
            for (int d = 0; d < 2; d++) tready[d] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, gap timing.
    logic       pv [2], pr [2], plst [2];
    logic [7:0] pd [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (tvalid[d] && !pv[d]) gap_meas[d] = cyc - tl_cyc[d];
                if (pv[d] && !pr[d]) begin
                    chk($sformatf("stall_valid%0d", d), 64'(tvalid[d]), 1);
                    chk($sformatf("stall_data%0d", d), 64'(tdata[d]), 64'(pd[d]));
                    chk($sformatf("stall_last%0d", d), 64'(tlast[d]), 64'(plst[d]));
                end
                if (tvalid[d]) chk($sformatf("ready_in_frame%0d", d), 64'(cmd_ready[d]), 0);
                if (tvalid[d] && tready[d]) begin
                    chk($sformatf("beat%0d_%0d", d, beat_cnt[d]), 64'({tlast[d], tdata[d]}), 64'(sb_pop(d)));
                    beat_cnt[d]++;
                    if (tlast[d]) begin
                        last_len[d] = beat_cnt[d];
                        beat_cnt[d] = 0;
                        tl_cyc[d]   = cyc;
                    end
                end
                if (drop_pulse[d]) drop_seen[d]++;
            end
            pv[d] = tvalid[d]; pr[d] = tready[d]; pd[d] = tdata[d]; plst[d] = tlast[d];
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            beat_cnt[d] = 0; last_len[d] = 0; tl_cyc[d] = 0; gap_meas[d] = 0;
            drop_seen[d] = 0; exp_fc[d] = 0; exp_dc[d] = 0;
            pv[d] = 0; pr[d] = 1; pd[d] = 0; plst[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_tvalid", 64'(tvalid[0]), 0);
        chk("rst_tlast", 64'(tlast[0]), 0);
        chk("rst_tdata", 64'(tdata[0]), 0);
        chk("rst_ready", 64'(cmd_ready[0]), 0);
        chk("rst_busy", 64'(busy[0]), 0);
        chk("rst_fc", 64'(frame_count[0]), 0);
        chk("rst_dc", 64'(drop_count[0]), 0);
        chk("rst_drop_pulse", 64'(drop_pulse[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready[0]), 1);

        // 1: constant payload, 44 beats
        send(0, 11'd30, 48'h123456789ABC, 48'h111111111111, 16'h0008, 8'h1A);
        wait_idle(0, 500);
        chk("t1_len", 64'(last_len[0]), 44);
        chk("t1_fc", 64'(frame_count[0]), 1);

        // 2: incrementing payload with wrap, 314 beats
        send(1, 11'd300, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'hDD86, 8'hF0);
        wait_idle(1, 1000);
        chk("t2_len", 64'(last_len[1]), 314);
        chk("t2_fc", 64'(frame_count[1]), 1);

        // 3: back-to-back commands, gap timing
        send(0, 11'd20, 48'h0A0B0C0D0E0F, 48'h010203040506, 16'h0608, 8'h55);
        send(0, 11'd25, 48'hFFEEDDCCBBAA, 48'h998877665544, 16'h0008, 8'hC3);
        wait_idle(0, 500);
        chk("t3_gap_ifg12", 64'(gap_meas[0]), 15);
        send(1, 11'd5, 48'h1, 48'h2, 16'h3, 8'h10);
        send(1, 11'd6, 48'h4, 48'h5, 16'h6, 8'hFE);
        wait_idle(1, 500);
        chk("t3_gap_ifg0", 64'(gap_meas[1]), 3);
        chk("t3_fc", 64'(frame_count[0]), 64'(exp_fc[0]));

        // 4: random backpressure over 20 random frames
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++)
            send(0, 11'($urandom_range(1, 64)), 48'({$urandom(), $urandom()}),
                 48'({$urandom(), $urandom()}), 16'($urandom()), 8'($urandom()));
        for (int i = 0; i < 10; i++)
            send(1, 11'($urandom_range(1, 300)), 48'({$urandom(), $urandom()}),
                 48'({$urandom(), $urandom()}), 16'($urandom()), 8'($urandom()));
        wait_idle(0, 20000);
        wait_idle(1, 20000);
        rnd_rdy = 1'b0;
        chk("t4_fc0", 64'(frame_count[0]), 64'(exp_fc[0]));
        chk("t4_fc1", 64'(frame_count[1]), 64'(exp_fc[1]));

        // 5: illegal sizes dropped, legal one still correct
        send(0, 11'd0, 48'h1, 48'h2, 16'h3, 8'h44);
        send(0, 11'd1501, 48'h1, 48'h2, 16'h3, 8'h44);
        send(0, 11'd1500, 48'h777777777777, 48'h888888888888, 16'h0008, 8'h99);
        wait_idle(0, 3000);
        chk("t5_dc", 64'(drop_count[0]), 2);
        chk("t5_drop_pulses", 64'(drop_seen[0]), 2);
        chk("t5_len", 64'(last_len[0]), 1514);
        chk("t5_fc", 64'(frame_count[0]), 64'(exp_fc[0]));

        // 6: reset in the middle of a frame
        send(0, 11'd30, 48'h123456789ABC, 48'h111111111111, 16'h0008, 8'h1A);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (beat_cnt[0] < 20 && n < 200);
        chk("t6_reach_beat20", 64'(beat_cnt[0]), 20);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_tvalid", 64'(tvalid[0]), 0);
        chk("t6_tlast", 64'(tlast[0]), 0);
        chk("t6_fc", 64'(frame_count[0]), 0);
        chk("t6_dc", 64'(drop_count[0]), 0);
        chk("t6_busy", 64'(busy[0]), 0);
        sb0.delete();
        sb1.delete();
        for (int d = 0; d < 2; d++) begin
            beat_cnt[d] = 0; exp_fc[d] = 0; exp_dc[d] = 0; drop_seen[d] = 0;
        end
        rst = 1'b0;
        send(0, 11'd30, 48'hCAFEBABE0001, 48'h0002DEADBEEF, 16'h0081, 8'h3C);
        wait_idle(0, 500);
        chk("t6_len", 64'(last_len[0]), 44);
        chk("t6_fc_after", 64'(frame_count[0]), 1);
        chk("t6_sb_drained", 64'(sb0.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
